// File: rtl/rv32i_multicycle_pkg.sv
// Shared RV32I definitions: FSM states, opcodes, ALU/branch/immediate/memop encodings
// and the combinational helpers used by the multicycle core.
package rv32i_multicycle_pkg;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } aluctr_t;

    typedef enum logic [2:0] {EXT_I, EXT_S, EXT_B, EXT_U, EXT_J} extop_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;

    function automatic logic [31:0] immgen(input logic [31:0] ir, input extop_t ext);
        case (ext)
            EXT_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            EXT_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            EXT_U:   return {ir[31:12], 12'b0};
            EXT_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

    // Bit 30 selects SUB only for register-register ops; SRAI/SRA share it.
    function automatic aluctr_t aluctrof(input logic [2:0] f3, input logic bit30, input logic isimm);
        case (f3)
            3'b000:  return (bit30 && !isimm) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return bit30 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input aluctr_t ctr);
        case (ctr)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $signed(a) >>> b[4:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic branchtaken(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
        case (f3)
            BR_EQ:   return a == b;
            BR_NE:   return a != b;
            BR_LT:   return $signed(a) < $signed(b);
            BR_GE:   return $signed(a) >= $signed(b);
            BR_LTU:  return a < b;
            BR_GEU:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_regfile_sync.sv
// 31 x 32-bit register file: two asynchronous read ports, one write port on the
// rising clock; x0 is not stored and always reads zero.
module rv32_regfile_sync (
    input  logic        clock,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [31:1];

    always_ff @(posedge clock) begin
        if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/rv32i_multicycle.sv
// Multicycle RV32I core: FETCH -> EXEC -> (MEM -> (WB)) with one instruction in
// flight; faults and ECALL/EBREAK park the core in HALT until reset.
module rv32i_multicycle
    import rv32i_multicycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          CNT_W           = 32,
    parameter int          HALT_ON_ILLEGAL = 1
) (
    input  logic             clock,
    input  logic             reset,
    output logic [31:0]      imemaddr,
    output logic             imemreq,
    input  logic             imemready,
    input  logic [31:0]      imemdataout,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemdatain,
    input  logic [31:0]      dmemdataout,
    output logic [2:0]       dmemop,
    output logic             dmemwe,
    output logic             dmemreq,
    input  logic             dmemready,
    output logic             halted,
    output logic [CNT_W-1:0] instret,
    output logic [31:0]      dbgdata
);

    state_t      state;
    logic [31:0] pc, ir, mdr, addrreg, storereg;

    extop_t  extop;
    aluctr_t aluctr;
    logic    srcapc, srcazero, srcbimm, regwr;
    logic    isload, isstore, isbranch, isjal, isjalr, issystem, illegal;

    always_comb begin
        extop    = EXT_I;
        aluctr   = ALU_ADD;
        srcapc   = 1'b0;
        srcazero = 1'b0;
        srcbimm  = 1'b1;
        regwr    = 1'b0;
        isload   = 1'b0;
        isstore  = 1'b0;
        isbranch = 1'b0;
        isjal    = 1'b0;
        isjalr   = 1'b0;
        issystem = 1'b0;
        illegal  = 1'b0;
        case (ir[6:0])
            OP_LUI:    begin extop = EXT_U; srcazero = 1'b1; regwr = 1'b1; end
            OP_AUIPC:  begin extop = EXT_U; srcapc = 1'b1; regwr = 1'b1; end
            OP_JAL:    begin extop = EXT_J; isjal = 1'b1; regwr = 1'b1; end
            OP_JALR:   begin isjalr = 1'b1; regwr = 1'b1; end
            OP_BRANCH: begin extop = EXT_B; isbranch = 1'b1; end
            OP_LOAD:   isload = 1'b1;
            OP_STORE:  begin extop = EXT_S; isstore = 1'b1; end
            OP_IMM:    begin aluctr = aluctrof(ir[14:12], ir[30], 1'b1); regwr = 1'b1; end
            OP_REG:    begin aluctr = aluctrof(ir[14:12], ir[30], 1'b0); srcbimm = 1'b0; regwr = 1'b1; end
            OP_FENCE:  ;
            OP_SYSTEM: issystem = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

    logic [31:0] imm, rs1v, rs2v, alua, alub, aluresult, target, nextpc, rfwdata;
    logic        taken, misaligned, haltnow, rfwe;

    assign imm        = immgen(ir, extop);
    assign alua       = srcazero ? 32'd0 : (srcapc ? pc : rs1v);
    assign alub       = srcbimm ? imm : rs2v;
    assign aluresult  = alu(alua, alub, aluctr);
    assign taken      = isjal | isjalr | (isbranch & branchtaken(rs1v, rs2v, ir[14:12]));
    assign target     = isjalr ? (aluresult & ~32'd1) : (pc + imm);
    assign nextpc     = taken ? target : (pc + 32'd4);
    assign misaligned = taken & (target[1:0] != 2'b00);
    assign haltnow    = issystem | misaligned | (illegal & (HALT_ON_ILLEGAL != 0));

    // Loads/stores never write in EXEC because their regwr is clear.
    assign rfwe    = ~reset & (((state == S_EXEC) & ~haltnow & regwr) | (state == S_WB));
    assign rfwdata = (state == S_WB) ? mdr : ((isjal | isjalr) ? (pc + 32'd4) : aluresult);

    rv32_regfile_sync u_regfile (
        .clock  (clock),
        .we     (rfwe),
        .waddr  (ir[11:7]),
        .wdata  (rfwdata),
        .raddr1 (ir[19:15]),
        .raddr2 (ir[24:20]),
        .rdata1 (rs1v),
        .rdata2 (rs2v)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            instret  <= '0;
            ir       <= 32'd0;
            mdr      <= 32'd0;
            addrreg  <= 32'd0;
            storereg <= 32'd0;
        end else begin
            case (state)
                S_FETCH: if (imemready) begin
                    ir    <= imemdataout;
                    state <= S_EXEC;
                end
                S_EXEC: if (haltnow) begin
                    state <= S_HALT;
                end else if (isload | isstore) begin
                    addrreg  <= aluresult;
                    storereg <= rs2v;
                    state    <= S_MEM;
                end else begin
                    pc      <= nextpc;
                    instret <= instret + CNT_W'(1);
                    state   <= S_FETCH;
                end
                S_MEM: if (dmemready) begin
                    if (isstore) begin
                        pc      <= pc + 32'd4;
                        instret <= instret + CNT_W'(1);
                        state   <= S_FETCH;
                    end else begin
                        mdr   <= dmemdataout;
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    pc      <= pc + 32'd4;
                    instret <= instret + CNT_W'(1);
                    state   <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Request strobes are masked by reset so a pending handshake drops immediately.
    assign imemaddr   = pc;
    assign imemreq    = (state == S_FETCH) & ~reset;
    assign dmemreq    = (state == S_MEM) & ~reset;
    assign dmemwe     = dmemreq & isstore;
    assign dmemaddr   = addrreg;
    assign dmemdatain = storereg;
    assign dmemop     = ir[14:12];
    assign halted     = (state == S_HALT);
    assign dbgdata    = pc;

endmodule

// File: tb/tb_rv32i_multicycle.sv
// Directed bench for rv32i_multicycle: one core with halting on illegal opcodes,
// a second one retiring illegal opcodes as NOPs with a 4-bit instret.
module tb_rv32i_multicycle;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetA, resetB;
    logic [31:0] imemaddrA, imemdataoutA, dmemaddrA, dmemdatainA, dmemdataoutA, dbgdataA;
    logic        imemreqA, imemreadyA, dmemweA, dmemreqA, dmemreadyA, haltedA;
    logic [2:0]  dmemopA;
    logic [31:0] instretA;
    logic [31:0] imemaddrB, imemdataoutB, dmemaddrB, dmemdatainB, dmemdataoutB, dbgdataB;
    logic        imemreqB, imemreadyB, dmemweB, dmemreqB, dmemreadyB, haltedB;
    logic [2:0]  dmemopB;
    logic [3:0]  instretB;

    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:63];
    int dWait = 0;
    int dCnt = 0;
    int checks = 0;
    int errors = 0;
    int cycles, reqCycles;
    logic weSeen;
    logic [31:0] stAddr, stData;
    logic [2:0] stOp;

    function automatic logic [6:0] idx(input logic [31:0] a);
        logic [31:0] o;
        o = (a - 32'h100) >> 2;
        return o[6:0];
    endfunction

    rv32i_multicycle #(.RESET_PC(32'h100), .CNT_W(32), .HALT_ON_ILLEGAL(1)) dutA (
        .clock(clock), .reset(resetA),
        .imemaddr(imemaddrA), .imemreq(imemreqA), .imemready(imemreadyA), .imemdataout(imemdataoutA),
        .dmemaddr(dmemaddrA), .dmemdatain(dmemdatainA), .dmemdataout(dmemdataoutA), .dmemop(dmemopA),
        .dmemwe(dmemweA), .dmemreq(dmemreqA), .dmemready(dmemreadyA),
        .halted(haltedA), .instret(instretA), .dbgdata(dbgdataA)
    );

    rv32i_multicycle #(.RESET_PC(32'h100), .CNT_W(4), .HALT_ON_ILLEGAL(0)) dutB (
        .clock(clock), .reset(resetB),
        .imemaddr(imemaddrB), .imemreq(imemreqB), .imemready(imemreadyB), .imemdataout(imemdataoutB),
        .dmemaddr(dmemaddrB), .dmemdatain(dmemdatainB), .dmemdataout(dmemdataoutB), .dmemop(dmemopB),
        .dmemwe(dmemweB), .dmemreq(dmemreqB), .dmemready(dmemreadyB),
        .halted(haltedB), .instret(instretB), .dbgdata(dbgdataB)
    );

    assign imemreadyA   = imemreqA;
    assign imemdataoutA = imem[idx(imemaddrA)];
    assign dmemreadyA   = dmemreqA && (dCnt >= dWait);
    assign dmemdataoutA = dmem[dmemaddrA[7:2]];
    assign imemreadyB   = imemreqB;
    assign imemdataoutB = imem[idx(imemaddrB)];
    assign dmemreadyB   = dmemreqB;
    assign dmemdataoutB = 32'd0;

    // Data memory for core A with a programmable number of wait cycles per access.
    always @(posedge clock) begin
        dCnt <= dmemreqA ? dCnt + 1 : 0;
        if (dmemreqA && dmemweA && dmemreadyA)
            dmem[dmemaddrA[7:2]] <= dmemdatainA;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs core A from a FETCH cycle to the next FETCH, recording the data-side activity.
    task automatic applyStimulus();
        cycles = 0; reqCycles = 0; weSeen = 1'b0;
        stAddr = 32'd0; stData = 32'd0; stOp = 3'd0;
        do begin
            if (dmemreqA) begin
                reqCycles++;
                weSeen = weSeen | dmemweA;
                if (dmemweA) begin stAddr = dmemaddrA; stData = dmemdatainA; stOp = dmemopA; end
            end
            step();
            cycles++;
        end while (!imemreqA && !haltedA && cycles < 40);
        checkOutput("nextFetch", {31'd0, imemreqA}, 32'd1);
    endtask

    initial begin
        resetA = 1'b1; resetB = 1'b1; dWait = 2;
        for (int i = 0; i < 128; i++) imem[i] = 32'h0000_0013;
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
        imem[0]  = 32'h0050_0093;   // addi x1,x0,5
        imem[1]  = 32'hFFD0_8113;   // addi x2,x1,-3
        imem[2]  = 32'h0020_2423;   // sw x2,8(x0)
        imem[3]  = 32'h0080_2183;   // lw x3,8(x0)
        imem[4]  = 32'h0030_2623;   // sw x3,12(x0)
        imem[5]  = 32'h2010_00E7;   // jalr x1,x0,0x201
        imem[64] = 32'h0010_2823;   // sw x1,16(x0)
        imem[65] = 32'h0000_0073;   // ecall
        step(); step();
        checkOutput("rstImemreq", {31'd0, imemreqA}, 32'd0);
        checkOutput("rstDmemreq", {31'd0, dmemreqA}, 32'd0);
        checkOutput("rstHalted", {31'd0, haltedA}, 32'd0);
        checkOutput("rstInstret", instretA, 32'd0);
        checkOutput("rstPc", dbgdataA, 32'h100);
        resetA = 1'b0; #1;
        checkOutput("firstReq", {31'd0, imemreqA}, 32'd1);
        checkOutput("firstAddr", imemaddrA, 32'h100);

        applyStimulus();
        checkOutput("addi1Cyc", cycles, 32'd2);
        checkOutput("addi1Next", imemaddrA, 32'h104);
        applyStimulus();
        checkOutput("addi2Cyc", cycles, 32'd2);
        checkOutput("addi2Instret", instretA, 32'd2);
        applyStimulus();
        checkOutput("swCyc", cycles, 32'd5);
        checkOutput("swReqCyc", reqCycles, 32'd3);
        checkOutput("swWe", {31'd0, weSeen}, 32'd1);
        checkOutput("swAddr", stAddr, 32'd8);
        checkOutput("swDataX2", stData, 32'd2);
        checkOutput("swOp", {29'd0, stOp}, 32'd2);
        applyStimulus();
        checkOutput("lwCyc", cycles, 32'd6);
        checkOutput("lwReqCyc", reqCycles, 32'd3);
        checkOutput("lwNoWe", {31'd0, weSeen}, 32'd0);
        applyStimulus();
        checkOutput("swX3", stData, 32'd2);
        checkOutput("swX3Addr", stAddr, 32'd12);
        applyStimulus();
        checkOutput("jalrCyc", cycles, 32'd2);
        checkOutput("jalrTarget", imemaddrA, 32'h200);
        applyStimulus();
        checkOutput("jalrLink", stData, 32'h118);
        step(); step();
        checkOutput("ecallHalted", {31'd0, haltedA}, 32'd1);
        checkOutput("ecallImemreq", {31'd0, imemreqA}, 32'd0);
        checkOutput("ecallInstret", instretA, 32'd7);
        checkOutput("ecallPc", dbgdataA, 32'h204);
        step(); step(); step();
        checkOutput("haltStays", {31'd0, haltedA}, 32'd1);
        checkOutput("haltNoReq", {30'd0, imemreqA, dmemreqA}, 32'd0);

        // Branch loop, x0 write discard, zero-wait store, reset during MEM.
        resetA = 1'b1; dWait = 0;
        imem[0] = 32'h0070_0013;    // addi x0,x0,7
        imem[1] = 32'h0000_2A23;    // sw x0,20(x0)
        imem[2] = 32'hFE00_0CE3;    // beq x0,x0,-8
        step();
        checkOutput("rstFromHalt", {31'd0, haltedA}, 32'd0);
        resetA = 1'b0; #1;
        applyStimulus();
        applyStimulus();
        checkOutput("swZeroWaitCyc", cycles, 32'd3);
        checkOutput("x0Discard", stData, 32'd0);
        applyStimulus();
        checkOutput("beqCyc", cycles, 32'd2);
        checkOutput("beqTarget", imemaddrA, 32'h100);
        checkOutput("beqInstret", instretA, 32'd3);
        dWait = 5;
        applyStimulus();
        step(); step();
        checkOutput("midMemReq", {31'd0, dmemreqA}, 32'd1);
        resetA = 1'b1; #1;
        checkOutput("rstMaskDreq", {31'd0, dmemreqA}, 32'd0);
        checkOutput("rstMaskIreq", {31'd0, imemreqA}, 32'd0);
        step();
        checkOutput("rstMemDreq", {31'd0, dmemreqA}, 32'd0);
        checkOutput("rstMemInstret", instretA, 32'd0);
        checkOutput("rstMemPc", dbgdataA, 32'h100);
        resetA = 1'b0; #1;
        checkOutput("rstMemFetch", {31'd0, imemreqA}, 32'd1);

        // Illegal opcode halts core A without retiring.
        resetA = 1'b1; imem[0] = 32'h0000_0000;
        step(); resetA = 1'b0; #1;
        step(); step();
        checkOutput("illHalted", {31'd0, haltedA}, 32'd1);
        checkOutput("illInstret", instretA, 32'd0);
        checkOutput("illPc", dbgdataA, 32'h100);
        step(); step();
        checkOutput("illNoReq", {30'd0, imemreqA, dmemreqA}, 32'd0);

        // jal with a target two bytes off word alignment halts.
        resetA = 1'b1; imem[0] = 32'h0060_00EF;   // jal x1,6
        step(); resetA = 1'b0; #1;
        step(); step();
        checkOutput("misHalted", {31'd0, haltedA}, 32'd1);
        checkOutput("misPc", dbgdataA, 32'h100);
        checkOutput("misInstret", instretA, 32'd0);

        // Core B: illegal retires as NOP, then the 4-bit counter wraps after 17 retirements.
        resetA = 1'b1;
        imem[0] = 32'h0000_0000;
        for (int i = 1; i < 40; i++) imem[i] = 32'h0000_0013;
        step();
        resetB = 1'b0; #1;
        checkOutput("bFirstAddr", imemaddrB, 32'h100);
        step(); step();
        checkOutput("bIllNotHalted", {31'd0, haltedB}, 32'd0);
        checkOutput("bIllInstret", {28'd0, instretB}, 32'd1);
        checkOutput("bIllPc", imemaddrB, 32'h104);
        repeat (32) step();
        checkOutput("bWrapInstret", {28'd0, instretB}, 32'd1);
        checkOutput("bWrapPc", imemaddrB, 32'h144);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_multicycle.md
RV32I_MULTICYCLE -- requirements
Module: rv32i_multicycle

Interface
REQ-001 The block SHALL take parameter RESET_PC, default 32'h0000_0000, as the PC value loaded on reset.
REQ-002 The block SHALL take parameter CNT_W, default 32, as the width of the retired-instruction counter.
REQ-003 The block SHALL take parameter HALT_ON_ILLEGAL, default 1; when 1, illegal opcodes halt the core, and when 0 they retire as NOP.
REQ-004 The block SHALL provide port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL provide port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL provide port imemaddr  out  32  fetch address (current PC).
REQ-007 The block SHALL provide port imemreq  out  1  fetch request.
REQ-008 The block SHALL provide port imemready  in  1  fetch data valid this cycle.
REQ-009 The block SHALL provide port imemdataout  in  32  fetched instruction.
REQ-010 The block SHALL provide port dmemaddr  out  32  load/store address (ALU result).
REQ-011 The block SHALL provide port dmemdatain  out  32  store data (rs2).
REQ-012 The block SHALL provide port dmemdataout  in  32  load data, already extended per dmemop.
REQ-013 The block SHALL provide port dmemop  out  3  access size/sign (func3 encoding).
REQ-014 The block SHALL provide port dmemwe  out  1  write enable, asserted only with dmemreq.
REQ-015 The block SHALL provide port dmemreq  out  1  data request.
REQ-016 The block SHALL provide port dmemready  in  1  data access complete this cycle.
REQ-017 The block SHALL provide port halted  out  1  core stopped in HALT.
REQ-018 The block SHALL provide port instret  out  CNT_W  retired-instruction count.
REQ-019 The block SHALL provide port dbgdata  out  32  current PC.

Function
REQ-020 The block SHALL implement states FETCH, EXEC, MEM, WB, HALT, with one instruction in flight at a time.
REQ-021 FETCH: imemreq=1 and imemaddr=PC held stable until imemready=1; on that edge, IR<=imemdataout and next state is EXEC.
REQ-022 EXEC: decode IR, read rs1/rs2, compute the ALU result and branch condition; ALU, JAL, JALR, LUI and AUIPC retire here and go to FETCH.
REQ-023 EXEC, load or store: latch the address and store data, then go to MEM.
REQ-024 MEM: dmemreq=1 with address, data, op and we held stable until dmemready=1.
REQ-025 MEM, store completion: retire and go to FETCH.
REQ-026 MEM, load completion: latch dmemdataout into MDR and go to WB.
REQ-027 WB: write MDR to rd, retire, go to FETCH.
REQ-028 Retire SHALL mean: register write if regwr and rd!=0; PC<=next PC (PC+4, branch/JAL target PC+imm, JALR target (rs1+imm)&~1); instret+1.
REQ-029 instret SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-030 With zero-wait memories, cycles per instruction SHALL be 2 for ALU/branch/jump, 3 for store, 4 for load; each wait cycle adds exactly 1.
REQ-031 ECALL, EBREAK, a taken branch/jump target with bits[1:0]!=0, or (HALT_ON_ILLEGAL=1) an illegal opcode SHALL enter HALT from EXEC without retiring: no register write, PC and instret unchanged.
REQ-032 HALT: imemreq=dmemreq=dmemwe=0 and halted=1; the state is left only by reset.
REQ-033 x0 SHALL always read 0; writes to rd=0 SHALL be discarded.
REQ-034 imemreq and dmemreq SHALL never be asserted in the same cycle.

Reset
REQ-035 reset=1 at a rising edge SHALL set state=FETCH, PC=RESET_PC, instret=0, IR=0, MDR=0, halted=0, from any state, including mid-request.
REQ-036 While reset=1, imemreq, dmemreq and dmemwe SHALL be 0; a ready arriving during reset SHALL be ignored.
REQ-037 Register-file contents SHALL NOT be cleared by reset.
REQ-038 First fetch after reset deassertion SHALL request RESET_PC in the first cycle with reset=0.

Structure
REQ-039 A shared package SHALL hold the state enum, RV32I opcode constants, and the ALUctr, branch, extop and memop encodings, all common with the existing decoder, immediate and ALU blocks.
REQ-040 The existing immediate generator, control generator, ALU and branch-condition blocks SHALL be reused unchanged.
REQ-041 One new sub-module, rv32_regfile_sync (2 read ports, 1 synchronous write port on rising clock, x0 hardwired), is natural; the FSM and datapath registers stay in the top.

Verification
REQ-042 RESET_PC=32'h100, zero-wait; program addi x1,x0,5; addi x2,x1,-3 -> imemaddr 0x100 then 0x104; x2=2; instret=2 after 4 cycles.
REQ-043 sw x2,8(x0) then lw x3,8(x0), dmemready delayed 2 cycles each -> dmemreq held 3 cycles each; dmemwe only on sw; x3=2; store takes 5 cycles, load 6.
REQ-044 beq x0,x0,-8 at 0x108 -> next imemaddr=0x100; jalr x1,x0,0x201 -> PC=0x200, x1=PC+4.
REQ-045 Opcode 7'h00 with HALT_ON_ILLEGAL=1 -> halted=1, instret frozen, no requests; with HALT_ON_ILLEGAL=0 -> PC+4, instret+1.
REQ-046 reset pulsed during MEM with dmemreq=1 -> next cycle dmemreq=0, state FETCH, PC=RESET_PC, instret=0.
REQ-047 CNT_W=4, 17 NOPs retired -> instret=1.
